// File: rtl/stage2_conv_window.sv
// Stage-2 convolution window generator: turns the pooled 12x12 raster stream
// into every 5x5 stride-1 window. Each window comes out as one flat bus.
module stage2_conv_window #(
    parameter int unsigned IBW = 19,
    parameter int unsigned X   = 12,
    parameter int unsigned Y   = 12,
    parameter int unsigned KX  = 5,
    parameter int unsigned KY  = 5
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             i_in_valid,
    input  logic [IBW-1:0]                   i_in_fmap,
    output logic                             o_ot_valid,
    output logic [KY*KX*IBW-1:0]             o_ot_window,
    output logic [$clog2(Y-KY+1)-1:0]        o_ot_row,
    output logic [$clog2(X-KX+1)-1:0]        o_ot_col,
    output logic                             o_ot_last
);

    localparam int unsigned CW  = $clog2(X);
    localparam int unsigned RW  = $clog2(Y);
    localparam int unsigned ORW = $clog2(Y-KY+1);
    localparam int unsigned OCW = $clog2(X-KX+1);
    localparam int unsigned WW  = KY*KX*IBW;

    logic [CW-1:0]  col;
    logic [RW-1:0]  row;
    logic           col_end_c;
    logic           row_end_c;
    logic           emit_c;

    logic [IBW-1:0] lb        [KY-1][X];
    logic [IBW-1:0] win       [KY][KX];
    logic [IBW-1:0] newcol_c  [KY];
    logic [IBW-1:0] win_nxt_c [KY][KX];
    logic [WW-1:0]  win_flat_c;

    assign col_end_c = (col == CW'(X-1));
    assign row_end_c = (row == RW'(Y-1));
    // A window closes once the sample sits at least KY-1 rows and KX-1 columns in.
    assign emit_c    = i_in_valid && (row >= RW'(KY-1)) && (col >= CW'(KX-1));

    // Raster position of the next accepted sample; wrapping implies a new frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col <= '0;
            row <= '0;
        end else if (i_in_valid) begin
            if (col_end_c) begin
                col <= '0;
                row <= row_end_c ? '0 : row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    // Newest column: oldest buffered row on top, the live sample at the bottom.
    always_comb begin
        for (int unsigned ky = 0; ky < KY-1; ky++) begin
            newcol_c[ky] = lb[KY-2-ky][col];
        end
        newcol_c[KY-1] = i_in_fmap;
    end

    always_comb begin
        for (int unsigned ky = 0; ky < KY; ky++) begin
            for (int unsigned kx = 0; kx < KX-1; kx++) begin
                win_nxt_c[ky][kx] = win[ky][kx+1];
            end
            win_nxt_c[ky][KX-1] = newcol_c[ky];
        end
    end

    always_comb begin
        win_flat_c = '0;
        for (int unsigned ky = 0; ky < KY; ky++) begin
            for (int unsigned kx = 0; kx < KX; kx++) begin
                win_flat_c[(ky*KX+kx)*IBW +: IBW] = win_nxt_c[ky][kx];
            end
        end
    end

    // Data storage is never exposed before being overwritten, so it needs no reset.
    always_ff @(posedge clk) begin
        if (i_in_valid) begin
            for (int unsigned k = KY-2; k > 0; k--) begin
                lb[k][col] <= lb[k-1][col];
            end
            lb[0][col] <= i_in_fmap;
            win        <= win_nxt_c;
        end
    end

    // The output register captures the post-shift window; it holds while nothing is emitted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_ot_valid  <= 1'b0;
            o_ot_last   <= 1'b0;
            o_ot_window <= '0;
            o_ot_row    <= '0;
            o_ot_col    <= '0;
        end else begin
            o_ot_valid <= emit_c;
            o_ot_last  <= emit_c && row_end_c && col_end_c;
            if (emit_c) begin
                o_ot_window <= win_flat_c;
                o_ot_row    <= ORW'(row - RW'(KY-1));
                o_ot_col    <= OCW'(col - CW'(KX-1));
            end
        end
    end

endmodule

// File: tb/tb_stage2_conv_window.sv
// Scoreboard bench for stage2_conv_window. A driver pushes expected windows
// from a frame-image model, and a monitor pops one entry on each o_ot_valid.
module tb_stage2_conv_window;

    localparam int unsigned IBW = 19;
    localparam int unsigned WW  = 475;

    typedef struct packed {
        logic [WW-1:0] win;
        logic [2:0]    row;
        logic [2:0]    col;
        logic          last;
        logic [31:0]   cyc;
    } exp_t;

    logic            clk;
    logic            reset;
    logic            i_in_valid;
    logic [IBW-1:0]  i_in_fmap;
    logic            o_ot_valid;
    logic [WW-1:0]   o_ot_window;
    logic [2:0]      o_ot_row;
    logic [2:0]      o_ot_col;
    logic            o_ot_last;

    stage2_conv_window dut (
        .clk         (clk),
        .reset       (reset),
        .i_in_valid  (i_in_valid),
        .i_in_fmap   (i_in_fmap),
        .o_ot_valid  (o_ot_valid),
        .o_ot_window (o_ot_window),
        .o_ot_row    (o_ot_row),
        .o_ot_col    (o_ot_col),
        .o_ot_last   (o_ot_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    exp_t           q[$];
    logic [IBW-1:0] img [12][12];
    int             m_row;
    int             m_col;
    int             n_chk  = 0;
    int             n_fail = 0;

    task automatic chk(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Model: keep the whole frame image and cut windows out of it directly.
    task automatic put(input logic [IBW-1:0] v);
        exp_t e;
        @(negedge clk);
        i_in_valid = 1'b1;
        i_in_fmap  = v;
        img[m_row][m_col] = v;
        if (m_row >= 4 && m_col >= 4) begin
            e.win = '0;
            for (int ky = 0; ky < 5; ky++) begin
                for (int kx = 0; kx < 5; kx++) begin
                    e.win[(ky*5+kx)*19 +: 19] = img[m_row-4+ky][m_col-4+kx];
                end
            end
            e.row  = 3'(m_row - 4);
            e.col  = 3'(m_col - 4);
            e.last = (m_row == 11 && m_col == 11);
            e.cyc  = cyc + 1;
            q.push_back(e);
        end
        if (m_col == 11) begin
            m_col = 0;
            m_row = (m_row == 11) ? 0 : m_row + 1;
        end else begin
            m_col = m_col + 1;
        end
    endtask

    task automatic idle();
        @(negedge clk);
        i_in_valid = 1'b0;
    endtask

    task automatic settle(input string name);
        repeat (4) @(negedge clk);
        chk(name, WW'(q.size()), WW'(0));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_valid"},  WW'(o_ot_valid),  WW'(0));
        chk({tag, "_last"},   WW'(o_ot_last),   WW'(0));
        chk({tag, "_window"}, o_ot_window,      WW'(0));
        chk({tag, "_row"},    WW'(o_ot_row),    WW'(0));
        chk({tag, "_col"},    WW'(o_ot_col),    WW'(0));
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (o_ot_valid === 1'b1) begin
                if (q.size() == 0) begin
                    chk("unexpected_valid", WW'(1), WW'(0));
                end else begin
                    e = q.pop_front();
                    chk("win_cycle", WW'(cyc),       WW'(e.cyc));
                    chk("win_row",   WW'(o_ot_row),  WW'(e.row));
                    chk("win_col",   WW'(o_ot_col),  WW'(e.col));
                    chk("win_last",  WW'(o_ot_last), WW'(e.last));
                    chk("win_data",  o_ot_window,    e.win);
                end
            end
        end
    endtask

    initial begin
        reset      = 1'b1;
        i_in_valid = 1'b0;
        i_in_fmap  = '0;
        m_row      = 0;
        m_col      = 0;
        fork
            monitor();
            begin
                #2000000;
                $display("FAIL watchdog: got timeout expected completion");
                $fatal(1, "watchdog expired");
            end
        join_none

        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        reset = 1'b0;

        // Back-to-back ramp: first window after sample 52, last with sample 143.
        for (int i = 0; i < 144; i++) put(IBW'(i));
        idle();
        settle("ramp_drain");

        // Same ramp with one idle cycle after every sample.
        for (int i = 0; i < 144; i++) begin
            put(IBW'(i));
            idle();
        end
        settle("gapped_drain");

        // Two frames with no gap between them.
        for (int i = 0; i < 144; i++) put(IBW'(i));
        for (int i = 0; i < 144; i++) put(IBW'(1000 + i));
        idle();
        settle("two_frame_drain");

        // Reset part-way through a frame, then a fresh ramp.
        for (int i = 0; i < 70; i++) put(IBW'(i));
        idle();
        settle("pre_reset_drain");
        @(negedge clk);
        #2 reset = 1'b1;
        #1 check_reset_outputs("midrst");
        q.delete();
        m_row = 0;
        m_col = 0;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 144; i++) put(IBW'(i));
        idle();
        settle("post_reset_drain");

        // All-ones data across the full bus width.
        for (int i = 0; i < 144; i++) put(19'h7FFFF);
        idle();
        settle("max_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/stage2_conv_window.md
# stage2_conv_window

Stage-2 convolution window generator: the receiving end of the stage-2 max-pooling output stream. Accepts the pooled 12x12 feature map as a row-major raster stream of 19-bit samples and emits every valid 5x5 window (stride 1, 8x8 = 64 windows per frame) as one flat packed bus. It sits between `stage2_pooling` and the stage-2 convolution datapath, which consumes one window per valid cycle.

## Interface
- `IBW`, 19, input sample bit width (matches pooling output width)
- `X`, 12, feature map width in pixels
- `Y`, 12, feature map height in pixels
- `KX`, 5, window width
- `KY`, 5, window height
- `clk`  input  1  single clock, rising edge
- `reset`  input  1  asynchronous, active-high reset
- `i_in_valid`  input  1  input sample strobe, one sample per high cycle
- `i_in_fmap`  input  IBW  input sample, raster order
- `o_ot_valid`  output  1  window valid, one-cycle pulse per window
- `o_ot_window`  output  KY*KX*IBW (475)  packed window; element (ky,kx) at bits [(ky*KX+kx)*IBW +: IBW], ky=0 is the top row, kx=0 the left column
- `o_ot_row`  output  3  window top-left row index, 0..7
- `o_ot_col`  output  3  window top-left column index, 0..7
- `o_ot_last`  output  1  high with the 64th window of a frame

## Operation
- Counters `col` (0..X-1) and `row` (0..Y-1) give the raster position of the next accepted sample; they advance only on `i_in_valid`. At col=X-1 `col` wraps to 0 and `row` increments; at (Y-1, X-1) both wrap to 0, so the next sample starts a new frame. No explicit frame-start signal exists.
- Line buffers: KY-1 = 4 rows of X entries each. On an accepted sample at column c, line buffer k's entry c moves up to buffer k+1 (k=0..2) and the sample is written into buffer 0 entry c. The newest column is formed from buffers 3,2,1,0 (top to bottom) plus the sample.
- Window register: 5x5 of IBW. On each accepted sample, columns shift left by one and the newest column enters at kx=4.
- A window is complete when the accepted sample is at row>=KY-1 and col>=KX-1. Window top-left is (row-4, col-4).
- Phases: FILL (row<4 or col<4: shifting only, no output) and EMIT (output on each accepted sample). Derived from the counters; no separate state register is needed.
- No arithmetic on data: pure reordering and delay; samples are passed through bit-exact.
- No backpressure: the consumer must accept every window in its valid cycle.
- Idle cycles (`i_in_valid`=0) freeze counters, line buffers and window register; a gapped stream produces the same windows as a back-to-back stream.

## Timing
- Reset (async assert, sampled release): `o_ot_valid`=0, `o_ot_last`=0, `o_ot_window`=0, `o_ot_row`=0, `o_ot_col`=0, `row`=`col`=0. Line buffer contents need not be cleared; they are never exposed before being overwritten in the new frame.
- Latency 1 cycle: a sample accepted at rising edge k that completes a window drives `o_ot_valid`=1 with the window, indices and `o_ot_last` from edge k until edge k+1.
- `o_ot_valid` is low in every cycle following an edge with `i_in_valid`=0 or with a FILL-phase sample. `o_ot_window`/indices hold their last value while `o_ot_valid`=0.
- `o_ot_last` is high only with window (7,7), i.e. with sample (11,11).
- Reset mid-frame: all outputs return to reset values immediately; the next accepted sample is treated as pixel (0,0).
- Back-to-back frames: sample (0,0) of frame n+1 may arrive in the cycle after sample (11,11) of frame n; the first window of frame n+1 appears only after its sample (4,4).

## Test plan
- Ramp: feed values 0..143 continuously -> first `o_ot_valid` one edge after sample 52 is accepted, row=col=0, element(ky,kx)=ky*12+kx (bottom-right = 52); exactly 64 valids; last has row=col=7, top-left 91, bottom-right 143, `o_ot_last`=1.
- Every window in the ramp frame: element(ky,kx) = (r+ky)*12+(c+kx), and (r,c) increments raster-wise 0..7.
- Gapped input: same ramp with `i_in_valid` low on every other cycle -> the identical 64 windows in the same order; no valid in gap-following cycles.
- Two frames back-to-back: ramp 0..143 then 1000..1143 -> 128 windows; window 65 top-left 1000, bottom-right 1052; second frame has no stale-data window.
- Reset mid-frame after 70 samples -> all outputs 0 within the reset cycle; fresh ramp afterwards reproduces the first scenario exactly.
- Max-value data: all samples 2^19-1 -> every window element 2^19-1, no truncation across the 475-bit bus.
